// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin write-port arbiter for a 32-entry register file.
// Optionally zeroes registers 1..31 after reset before serving requesters.
module rf_wr_arbiter #(
  parameter int unsigned INIT_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  input  logic [4:0]  req0_addr_i5,
  input  logic [31:0] req0_data_i32,
  output logic        req0_ready_o,

  input  logic        req1_valid_i,
  input  logic [4:0]  req1_addr_i5,
  input  logic [31:0] req1_data_i32,
  output logic        req1_ready_o,

  output logic        we3_o,
  output logic [4:0]  wa3_o5,
  output logic [31:0] wd3_o32,
  output logic        init_done_o,
  output logic [7:0]  drop_cnt_o8
);

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic ResetState = (INIT_EN != 0) ? StInit : StRun;

  logic        state_q, state_d;
  logic [4:0]  init_cnt_q, init_cnt_d;
  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic        prio_q, prio_d;
  logic        we3_q, we3_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        run_active;
  logic        grant0, grant1;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // init_done_q gates the grants so ready stays low while reset is held,
  // even when the block resets straight into RUN.
  assign run_active = (state_q == StRun) && init_done_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (run_active) begin
      if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid_i) begin
        grant1 = 1'b1;
      end
    end
  end

  assign xfer     = grant0 || grant1;
  assign sel_addr = grant0 ? req0_addr_i5  : req1_addr_i5;
  assign sel_data = grant0 ? req0_data_i32 : req1_data_i32;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prio_d     = prio_q;
    we3_d      = we3_q;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      StInit: begin
        // Counter wraps 31 -> 0 after the last zeroing write.
        if (init_cnt_q == 5'd0) begin
          state_d = StRun;
          we3_d   = 1'b0;
        end else begin
          we3_d      = 1'b1;
          wa3_d      = init_cnt_q;
          wd3_d      = 32'd0;
          init_cnt_d = init_cnt_q + 5'd1;
        end
      end
      StRun: begin
        we3_d = 1'b0;
        if (xfer) begin
          prio_d = grant0;
          if (sel_addr == 5'd0) begin
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end else begin
            we3_d = 1'b1;
            wa3_d = sel_addr;
            wd3_d = sel_data;
          end
        end
      end
    endcase

    init_done_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      init_cnt_q  <= 5'd1;
      prio_q      <= 1'b0;
      we3_q       <= 1'b0;
      wa3_q       <= 5'd0;
      wd3_q       <= 32'd0;
      init_done_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      prio_q      <= prio_d;
      we3_q       <= we3_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
      init_done_q <= init_done_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign we3_o        = we3_q;
  assign wa3_o5       = wa3_q;
  assign wd3_o32      = wd3_q;
  assign init_done_o  = init_done_q;
  assign drop_cnt_o8  = drop_cnt_q;

endmodule
